// File: rtl/bin_frac_seq_div_pkg.sv
// Shared definitions for the fractional multiply/divide blocks.
//   FRAC_N  : operand width. The multiplier and its bench use it too.
//   state_t : divider sequencer states.
package bin_frac_seq_div_pkg;
    localparam int FRAC_N = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/bin_frac_seq_div_seq_iter_counter.sv
// Iteration counter for bit-serial arithmetic sequencers.
//   clk, rst : clock, synchronous active-high reset
//   clr      : load edge, restart the count at 0 (wins over en)
//   en       : advance by one
//   last     : count is at N-1, so the current iteration is the final one
module seq_iter_counter #(
    parameter int N = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)     count_d = '0;
        else if (en) count_d = count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign last = (count_q == W'(N - 1));
endmodule

// File: rtl/bin_frac_seq_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one
// quotient bit per clock. With dividend[2N-1:N] < divisor the quotient is
// the N-bit fraction dividend / (divisor * 2^N).
//   clk, rst    : clock, synchronous active-high reset
//   start       : load operands and (re)start, honoured in every state
//   dividend    : 2N-bit unsigned, captured on the start edge
//   divisor     : N-bit unsigned, captured on the start edge
//   done        : results valid
//   quotient    : N-bit quotient (valid with done)
//   remainder   : N-bit remainder (valid with done)
//   overflow    : quotient does not fit in N bits (valid with done)
//   div_by_zero : divisor was zero (valid with done)
module bin_frac_seq_div
    import bin_frac_seq_div_pkg::*;
#(
    parameter int N = FRAC_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           overflow,
    output logic           div_by_zero
);
    state_t       state_q, state_d;
    logic [N:0]   r_q, r_d;      // partial remainder
    logic [N-1:0] q_q, q_d;      // low dividend bits shifting out, quotient bits shifting in
    logic [N-1:0] d_q, d_d;
    logic         ovf_q, ovf_d;
    logic         dbz_q, dbz_d;
    logic         done_q, done_d;

    logic         cnt_clr, cnt_en, cnt_last;
    logic [N-1:0] hi;
    logic [N+1:0] r_sh, t;

    seq_iter_counter #(.N(N)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (cnt_last)
    );

    assign hi   = dividend[2*N-1:N];
    // R[N] is always 0 between iterations (R < D), so {R, Qmsb} is the
    // shifted remainder already zero-extended to N+2 bits.
    assign r_sh = {r_q, q_q[N-1]};
    assign t    = r_sh - {2'b00, d_q};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        if (start) begin
            cnt_clr = 1'b1;
            d_d     = divisor;
            ovf_d   = 1'b0;
            dbz_d   = 1'b0;
            if (divisor == '0) begin
                state_d = DONE;
                dbz_d   = 1'b1;
                ovf_d   = 1'b1;
                q_d     = '1;
                r_d     = '0;
            end else if (hi >= divisor) begin
                state_d = DONE;
                ovf_d   = 1'b1;
                q_d     = '1;
                r_d     = {1'b0, hi};
            end else begin
                state_d = CALC;
                r_d     = {1'b0, hi};
                q_d     = dividend[N-1:0];
            end
        end else if (state_q == CALC) begin
            cnt_en = 1'b1;
            if (!t[N+1]) begin
                r_d = t[N:0];
                q_d = {q_q[N-2:0], 1'b1};
            end else begin
                r_d = r_sh[N:0];
                q_d = {q_q[N-2:0], 1'b0};
            end
            if (cnt_last) state_d = DONE;
        end

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign done        = done_q;
    assign quotient    = q_q;
    assign remainder   = r_q[N-1:0];
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
endmodule
